// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: round-robin arbiter that picks one requester per cycle
// and writes its data into a shared register.
`default_nettype none

module rr_reg_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [W-1:0]         q,
    output logic [$clog2(N)-1:0] owner,
    output logic                 valid
);

    localparam int IW = $clog2(N);

    logic [N-1:0]  gnt_q, gnt_d;
    logic [W-1:0]  data_q, data_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic          valid_q, valid_d;

    logic [N-1:0]  elig;
    logic [IW-1:0] win_idx;
    logic          win_vld;

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return s[IW-1:0];
    endfunction

    // The requester granted this cycle sits out the next edge.
    assign elig = req & ~gnt_q;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (elig[wrap_idx(ptr_q, off)]) begin
                win_vld = 1'b1;
                win_idx = wrap_idx(ptr_q, off);
            end
        end
    end

    always_comb begin
        gnt_d   = '0;
        valid_d = 1'b0;
        data_d  = data_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        if (win_vld) begin
            gnt_d[win_idx] = 1'b1;
            valid_d        = 1'b1;
            data_d         = wdata[win_idx*W +: W];
            owner_d        = win_idx;
            ptr_d          = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q   <= '0;
            data_q  <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            gnt_q   <= gnt_d;
            data_q  <= data_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
        end
    end

    assign gnt   = gnt_q;
    assign q     = data_q;
    assign owner = owner_q;
    assign valid = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
// tb_rr_reg_arbiter: scoreboard bench for rr_reg_arbiter (N=4, W=8).
`default_nettype none

module tb_rr_reg_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     owner;
    logic           valid;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [W-1:0] q;
        logic [1:0]   owner;
        logic         valid;
    } exp_t;

    exp_t exp_q[$];

    logic [N-1:0] m_gnt;
    logic [W-1:0] m_q;
    logic [1:0]   m_owner;
    logic [1:0]   m_ptr;
    logic         m_valid;

    int checks = 0;
    int errors = 0;

    rr_reg_arbiter #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .q     (q),
        .owner (owner),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gnt = '0; m_q = '0; m_owner = '0; m_ptr = '0; m_valid = 1'b0;
    endtask

    // Reference model: rotating search from the pointer over req & ~last grant.
    task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] wd);
        logic [N-1:0] e;
        bit           found;
        int           k;
        e = r & ~m_gnt;
        found = 0;
        k = 0;
        for (int off = 0; off < N; off++) begin
            if (!found && e[(int'(m_ptr) + off) % N]) begin
                found = 1;
                k = (int'(m_ptr) + off) % N;
            end
        end
        if (found) begin
            m_gnt   = 4'b0001 << k;
            m_q     = wd[k*W +: W];
            m_owner = 2'(k);
            m_valid = 1'b1;
            m_ptr   = 2'((k + 1) % N);
        end else begin
            m_gnt   = '0;
            m_valid = 1'b0;
        end
        exp_q.push_back('{gnt: m_gnt, q: m_q, owner: m_owner, valid: m_valid});
    endtask

    // Drive one cycle of stimulus, then compare the DUT against the scoreboard head.
    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] wd);
        exp_t e;
        req   = r;
        wdata = wd;
        model_step(r, wd);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("sb_gnt",   32'(gnt),   32'(e.gnt));
        chk("sb_q",     32'(q),     32'(e.q));
        chk("sb_owner", 32'(owner), 32'(e.owner));
        chk("sb_valid", 32'(valid), 32'(e.valid));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt),   32'd0);
        chk({tag, "_q"},     32'(q),     32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_valid"}, 32'(valid), 32'd0);
    endtask

    initial begin
        logic [3:0] all_g [5];
        logic [7:0] all_d [5];
        all_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        all_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

        rst_n = 1'b0;
        req   = '0;
        wdata = '0;
        model_reset();

        // Reset held with random inputs.
        for (int i = 0; i < 3; i++) begin
            req   = 4'($urandom);
            wdata = $urandom;
            @(posedge clk);
            #1;
            chk_zero("rst_hold");
        end
        req = '0;
        rst_n = 1'b1;

        // All request from reset: strict rotation.
        for (int i = 0; i < 5; i++) begin
            cycle(4'b1111, 32'h44332211);
            chk("all_gnt", 32'(gnt), 32'(all_g[i]));
            chk("all_q",   32'(q),   32'(all_d[i]));
        end
        cycle(4'b1111, 32'h44332211);
        cycle(4'b1111, 32'h44332211);
        chk("pre_async_gnt", 32'(gnt), 32'b0100);

        // Asynchronous reset mid-cycle while gnt=0100.
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester: granted every other cycle.
        for (int i = 0; i < 4; i++) begin
            cycle(4'b0010, {8'h00, 8'h00, 8'hA5, 8'h00});
            chk("single_gnt",   32'(gnt),   (i % 2 == 0) ? 32'b0010 : 32'b0000);
            chk("single_valid", 32'(valid), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("single_q",     32'(q),     32'hA5);
        end

        // Pointer at 2, req=0011: wrap to requester 0, then 1.
        cycle(4'b0011, 32'h0000_BBAA);
        chk("fair_gnt0", 32'(gnt), 32'b0001);
        cycle(4'b0011, 32'h0000_BBAA);
        chk("fair_gnt1", 32'(gnt), 32'b0010);
        chk("fair_q1",   32'(q),   32'hBB);

        // Idle hold after requester 3 writes 5A.
        cycle(4'b1000, 32'h5A00_0000);
        chk("idle_w_owner", 32'(owner), 32'd3);
        for (int i = 0; i < 5; i++) begin
            cycle(4'b0000, $urandom);
            chk("idle_q",     32'(q),     32'h5A);
            chk("idle_owner", 32'(owner), 32'd3);
            chk("idle_gnt",   32'(gnt),   32'd0);
        end
        cycle(4'b0001, 32'h0000_00C3);
        chk("idle_next_gnt", 32'(gnt), 32'b0001);

        // Random traffic.
        for (int i = 0; i < 60; i++)
            cycle(4'($urandom), $urandom);

        // Reset mid-stream, 30 time units low.
        cycle(4'b1111, 32'h44332211);
        cycle(4'b1111, 32'h44332211);
        rst_n = 1'b0;
        #1;
        chk_zero("stream_rst");
        #29;
        rst_n = 1'b1;
        model_reset();
        cycle(4'b1111, 32'h44332211);
        chk("post_rst_gnt", 32'(gnt), 32'b0001);
        cycle(4'b1111, 32'h44332211);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
